fp_add_arbiter: RTL
===================

# fp_add_arbiter

Round-robin arbiter and sequencer that shares a single 8-bit floating-point adder (operands `a`/`b`, `start` pulse in, `sum`/`valid` out) among `NREQ` requesters. It accepts one operand pair at a time, drives the adder operands and issues the `start` pulse. It then waits for `valid` and returns the sum to the granted requester over a valid/ready response. It sits between the stimulus/requester logic and the adder instance at the top level.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `W`, 8, operand/sum width; operands are opaque to this block
- `TIMEOUT`, 64, watchdog limit in cycles (used only with `FPARB_TIMEOUT_EN`)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester operand pair valid
- `req_ready`  out  NREQ  one-hot accept pulse
- `req_a`  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- `req_b`  in  NREQ*W  operand B, same packing
- `rsp_valid`  out  NREQ  one-hot result valid
- `rsp_ready`  in  NREQ  per-requester result accept
- `rsp_sum`  out  W  result, shared by all requesters
- `rsp_err`  out  1  result is a timeout abort
- `add_a`, `add_b`  out  W  adder operands, registered
- `add_start`  out  1  one-cycle start pulse to adder
- `add_sum`  in  W  adder result
- `add_valid`  in  1  adder result valid
- `busy`  out  1  state != IDLE
- `grant_id`  out  clog2(NREQ)  index of current grant

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward from `rr_ptr`, wrapping modulo NREQ.
  - Assert `req_ready[g]` combinationally for that cycle.
  - Latch `req_a[g]`/`req_b[g]` into `add_a`/`add_b` and `g` into `grant_id`.
  - Go to ISSUE.
- **ISSUE**
  - `add_start`=1 for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - Hold `add_a`/`add_b` stable.
  - On `add_valid`=1, register `add_sum` into `rsp_sum` and go to RESP.
- **RESP**
  - `rsp_valid[grant_id]`=1 and `rsp_sum` are held until `rsp_ready[grant_id]`=1.
  - On that cycle: `rr_ptr` <= (`grant_id`+1) mod NREQ, clear `rsp_err`, go to IDLE.
- `add_valid` is ignored in IDLE, ISSUE and RESP.
- `rsp_ready` bits of non-granted requesters are ignored.
- A requester may hold `req_valid` through its own response. It is re-arbitrated in IDLE, fairly, after the others.
- Only one request is in flight at a time; there is no queueing.
- Reset (async, `reset`=0) clears all outputs, the FSM and `rr_ptr`.
  - Reset values: state=IDLE, `rr_ptr`=0, `add_a`/`add_b`/`rsp_sum`=0, `add_start`/`rsp_err`=0, `req_ready`/`rsp_valid`=0, `busy`=0, `grant_id`=0.
  - Reset mid-operation discards the in-flight request. The system must reset the adder in the same event.

## Timing
- Accept at cycle 0 (`req_valid`&`req_ready`).
- `add_start` high in cycle 1.
- `add_valid` sampled in cycle t≥2 (WAIT) → `rsp_valid` high from cycle t+1.
- Minimum round trip: accept to `rsp_valid` = adder latency + 2.
- Back-to-back requests: the earliest next accept is the cycle after the `rsp_valid`&`rsp_ready` handshake (IDLE entered).
- `req_ready` is never high while `busy`=1.

## Configuration
- `FPARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT starting from 0.
  - If it reaches `TIMEOUT` with no `add_valid`, go to RESP with `rsp_sum`=0 and `rsp_err`=1.
  - `add_valid` in the same cycle the timeout fires wins: normal result, `rsp_err`=0.
- `FPARB_TIMEOUT_EN` undefined: WAIT holds indefinitely; `rsp_err` is tied to 0; no counter is built.

## Structure
- Package `fp_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - default `W`=8
  - the `TIMEOUT` default
- Sub-module `rr_picker`:
  - combinational round-robin search over `req_valid` from `rr_ptr`
  - outputs one-hot grant, index and `any`
- The adder is instantiated outside this block.

## Test plan
- Single request: requester 2 sends `a`=8'h4C, `b`=8'h31; the adder model has latency 3.
  - Required: `add_start` once, `add_a`=8'h4C, `add_b`=8'h31 held through WAIT.
  - Required: `rsp_valid`=4'b0100 with `rsp_sum` equal to the model sum; `rr_ptr` becomes 3.
- Fairness: all four `req_valid` held high with `rsp_ready` always 1.
  - Required: grants in order 0,1,2,3,0, with exactly one `add_start` per grant.
- Response backpressure: `rsp_ready[1]` held 0 for 10 cycles.
  - Required: `rsp_valid[1]` and `rsp_sum` stable for all 10 cycles; no new accept; `busy`=1.
- Spurious valid: `add_valid` pulsed in IDLE and in ISSUE.
  - Required: ignored, no `rsp_valid`.
  - Then a real `add_valid` in WAIT is processed normally.
- Reset mid-operation: `reset`=0 asserted during WAIT.
  - Required: all outputs go to 0 immediately (async), state IDLE, `rr_ptr`=0.
  - After release, a new request is served normally.
- Timeout (`FPARB_TIMEOUT_EN`, `TIMEOUT`=8): the adder never asserts valid.
  - Required: `rsp_valid` for the granted requester appears 8 cycles after entering WAIT, with `rsp_err`=1 and `rsp_sum`=8'h00.

Source files
------------

// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and defaults for the fp_add_arbiter slice.
// FPARB_TIMEOUT_EN (in fp_add_arbiter.sv) uses TIMEOUT_DEF as its watchdog limit.
package fp_arb_pkg;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester, response and adder-side signals of fp_add_arbiter.
// slave is the arbiter's view; master is the surrounding logic (requesters + adder).
interface fp_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_err;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_start;
  logic [W-1:0]      add_sum;
  logic              add_valid;
  logic              busy;
  logic [IW-1:0]     grant_id;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_sum, add_valid,
    output req_ready, rsp_valid, rsp_sum, rsp_err, add_a, add_b, add_start,
           busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_sum, add_valid,
    input  req_ready, rsp_valid, rsp_sum, rsp_err, add_a, add_b, add_start,
           busy, grant_id
  );

endinterface

// File: rtl/fp_add_arbiter_rr_picker.sv
// Combinational round-robin search over req starting at ptr, wrapping modulo NREQ.
// Outputs one-hot grant, its index, and whether any request is pending.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      logic [IW-1:0] j;
      j = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one adder among NREQ requesters, one request in flight.
// Define FPARB_TIMEOUT_EN to add a WAIT watchdog that returns rsp_err=1 after TIMEOUT cycles.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  fp_add_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_q;
  logic [W-1:0]    add_a_q, add_b_q, sum_q;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept, rsp_hs, result_in, timeout_hit;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign accept    = (state_q == IDLE) && pick_any;
  assign rsp_hs    = (state_q == RESP) && bus.rsp_ready[grant_q];
  assign result_in = (state_q == WAIT) && bus.add_valid;

`ifdef FPARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // Counts WAIT cycles from 0; fires on the TIMEOUT-th cycle unless a result arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                wait_cnt <= '0;
    else if (state_q != WAIT)  wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state_q == WAIT) && !bus.add_valid &&
                       (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
    else if (rsp_hs)      err_q <= 1'b0;
  end

  assign bus.rsp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.add_valid || timeout_hit) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_a_q <= '0;
      add_b_q <= '0;
      grant_q <= '0;
      sum_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      if (accept) begin
        add_a_q <= bus.req_a[int'(pick_idx)*W +: W];
        add_b_q <= bus.req_b[int'(pick_idx)*W +: W];
        grant_q <= pick_idx;
      end
      if (result_in)        sum_q <= bus.add_sum;
      else if (timeout_hit) sum_q <= '0;
      // The just-served requester drops to lowest priority for the next round.
      if (rsp_hs) rr_ptr <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign bus.req_ready = accept ? pick_gnt : '0;
  assign bus.rsp_valid = (state_q == RESP) ? (ONE << grant_q) : '0;
  assign bus.rsp_sum   = sum_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_start = (state_q == ISSUE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_id  = grant_q;

endmodule
